uart_txrx_cfg: RTL and testbench

UART_TXRX_CFG -- requirements
Module: uart_txrx_cfg

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_txrx_cfg.sv | 199 +++++++++++++++++++
 tb/tb_uart_txrx_cfg.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode constants, FSM state types and the parity helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE
    } rx_state_e;

    // Zero-extending narrower words to 8 bits leaves the XOR reduction unchanged.
    function automatic logic calc_parity(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, strobing tc_o on the last count.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 217,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc_o    = (count_q == LAST);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q + 1'b1;
        if (load_i || tc_o) count_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/uart_txrx_cfg.sv
// Full-duplex UART with build-time frame format (data bits, parity, stop bits) and loopback.
module uart_txrx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_uart_rx,
    output logic                 o_uart_tx,
    input  logic                 i_loopback,
    input  logic                 i_tx_dv,
    input  logic [DATA_BITS-1:0] i_tx_byte,
    output logic                 o_tx_ready,
    output logic                 o_tx_done,
    output logic                 o_rx_dv,
    output logic [DATA_BITS-1:0] o_rx_byte,
    output logic                 o_rx_parity_err,
    output logic                 o_rx_frame_err
);

    localparam int             CW          = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  TX_PRE_LAST = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0]  RX_HALF     = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [3:0]     LAST_DATA   = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_STOP   = 4'(STOP_BITS - 1);

    tx_state_e              tx_state_q;
    logic                   tx_q, tx_ready_q, tx_done_q, tx_par_q;
    logic [DATA_BITS-1:0]   tx_shift_q;
    logic [3:0]             tx_bit_q;
    logic [CW-1:0]          tx_cnt;
    logic                   tx_tc, tx_load, tx_accept;

    rx_state_e              rx_state_q;
    logic                   rx_meta_q, rx_sync_q, rx_in;
    logic                   rx_dv_q, rx_perr_q, rx_ferr_q, rx_parbit_q;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_byte_q;
    logic [3:0]             rx_bit_q;
    logic [CW-1:0]          rx_cnt;
    logic                   rx_tc, rx_load;

    assign tx_accept = i_tx_dv && tx_ready_q;
    assign tx_load   = (tx_state_q == TX_IDLE);
    assign rx_load   = (rx_state_q == RX_IDLE) || (rx_state_q == RX_START && rx_cnt == RX_HALF);
    assign rx_in     = i_loopback ? tx_q : i_uart_rx;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CW)) u_tx_timer (
        .clk_i(i_clk), .rst_i(i_reset), .load_i(tx_load), .count_o(tx_cnt), .tc_o(tx_tc)
    );

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CW)) u_rx_timer (
        .clk_i(i_clk), .rst_i(i_reset), .load_i(rx_load), .count_o(rx_cnt), .tc_o(rx_tc)
    );

    // Done and ready are raised one cycle early so both are visible in the frame's last cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b0;
            tx_par_q   <= 1'b0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
        end else begin
            tx_done_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_accept) begin
                        tx_state_q <= TX_START;
                        tx_q       <= 1'b0;
                        tx_ready_q <= 1'b0;
                        tx_shift_q <= i_tx_byte;
                        tx_par_q   <= calc_parity(8'(i_tx_byte), PARITY);
                    end
                end
                TX_START: begin
                    if (tx_tc) begin
                        tx_state_q <= TX_DATA;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_bit_q   <= '0;
                    end
                end
                TX_DATA: begin
                    if (tx_tc) begin
                        if (tx_bit_q != LAST_DATA) begin
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_bit_q   <= tx_bit_q + 4'd1;
                        end else if (PARITY != PAR_NONE) begin
                            tx_state_q <= TX_PARITY;
                            tx_q       <= tx_par_q;
                        end else begin
                            tx_state_q <= TX_STOP;
                            tx_q       <= 1'b1;
                            tx_bit_q   <= '0;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_tc) begin
                        tx_state_q <= TX_STOP;
                        tx_q       <= 1'b1;
                        tx_bit_q   <= '0;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_q == LAST_STOP && tx_cnt == TX_PRE_LAST) begin
                        tx_done_q  <= 1'b1;
                        tx_ready_q <= 1'b1;
                    end
                    if (tx_tc) begin
                        if (tx_bit_q != LAST_STOP) begin
                            tx_bit_q <= tx_bit_q + 4'd1;
                        end else if (tx_accept) begin
                            tx_state_q <= TX_START;
                            tx_q       <= 1'b0;
                            tx_ready_q <= 1'b0;
                            tx_shift_q <= i_tx_byte;
                            tx_par_q   <= calc_parity(8'(i_tx_byte), PARITY);
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // The start bit is checked mid-bit; its sample point reloads the timer so later tc strobes fall mid-bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_dv_q     <= 1'b0;
            rx_perr_q   <= 1'b0;
            rx_ferr_q   <= 1'b0;
            rx_parbit_q <= 1'b0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_bit_q    <= '0;
        end else begin
            rx_meta_q <= rx_in;
            rx_sync_q <= rx_meta_q;
            rx_dv_q   <= 1'b0;
            case (rx_state_q)
                RX_IDLE: if (!rx_sync_q) rx_state_q <= RX_START;
                RX_START: begin
                    if (rx_cnt == RX_HALF) begin
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                        rx_bit_q   <= '0;
                    end
                end
                RX_DATA: begin
                    if (rx_tc) begin
                        rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                        rx_bit_q   <= rx_bit_q + 4'd1;
                        if (rx_bit_q == LAST_DATA)
                            rx_state_q <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end
                end
                RX_PARITY: begin
                    if (rx_tc) begin
                        rx_parbit_q <= rx_sync_q;
                        rx_state_q  <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_tc) begin
                        rx_dv_q    <= 1'b1;
                        rx_byte_q  <= rx_shift_q;
                        rx_perr_q  <= (PARITY != PAR_NONE) &&
                                      (calc_parity(8'(rx_shift_q), PARITY) != rx_parbit_q);
                        rx_ferr_q  <= !rx_sync_q;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_WAIT_IDLE;
                    end
                end
                RX_WAIT_IDLE: if (rx_sync_q) rx_state_q <= RX_IDLE;
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign o_uart_tx       = tx_q;
    assign o_tx_ready      = tx_ready_q;
    assign o_tx_done       = tx_done_q;
    assign o_rx_dv         = rx_dv_q;
    assign o_rx_byte       = rx_byte_q;
    assign o_rx_parity_err = rx_perr_q;
    assign o_rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_txrx_cfg.sv
// Scoreboard bench for uart_txrx_cfg: 8N1, 8E1 and 8N2 instances driven with directed frames.
`timescale 1ns/1ps
module tb_uart_txrx_cfg;

    localparam int CPB = 217;

    typedef struct { int id; logic [7:0] data; logic perr; logic ferr; } rx_exp_t;
    typedef struct { int id; int cyc; } done_exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rx_in = 3'b111;
    logic [2:0] lb = 3'b000;
    logic [2:0] tx_dv = 3'b000;
    logic [7:0] tx_byte [3];
    logic [2:0] uart_tx, tx_ready, tx_done, rx_dv, perr, ferr;
    logic [7:0] rx_byte [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    rx_exp_t   rx_q[$];
    done_exp_t done_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_txrx_cfg #(
            .CLKS_PER_BIT(CPB), .DATA_BITS(8),
            .PARITY(g == 1 ? 1 : 0), .STOP_BITS(g == 2 ? 2 : 1)
        ) u_dut (
            .i_clk(clk), .i_reset(rst), .i_uart_rx(rx_in[g]), .o_uart_tx(uart_tx[g]),
            .i_loopback(lb[g]), .i_tx_dv(tx_dv[g]), .i_tx_byte(tx_byte[g]),
            .o_tx_ready(tx_ready[g]), .o_tx_done(tx_done[g]), .o_rx_dv(rx_dv[g]),
            .o_rx_byte(rx_byte[g]), .o_rx_parity_err(perr[g]), .o_rx_frame_err(ferr[g])
        );
    end

    function automatic int frame_len(input int k);
        return (k == 0) ? 10 * CPB : 11 * CPB;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rx_dv / tx_done must match the head of its queue.
    initial begin
        rx_exp_t   e;
        done_exp_t d;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (rx_dv[k]) begin
                    checks++;
                    if (rx_q.size() == 0) begin
                        errors++;
                        $display("FAIL rx_unexpected dut%0d: byte 0x%0h with no word expected", k, rx_byte[k]);
                    end else begin
                        e = rx_q.pop_front();
                        if (e.id != k || rx_byte[k] !== e.data || perr[k] !== e.perr || ferr[k] !== e.ferr) begin
                            errors++;
                            $display("FAIL rx_word dut%0d: got byte 0x%0h perr %0b ferr %0b, expected dut%0d byte 0x%0h perr %0b ferr %0b",
                                     k, rx_byte[k], perr[k], ferr[k], e.id, e.data, e.perr, e.ferr);
                        end
                    end
                end
                if (tx_done[k]) begin
                    checks++;
                    if (done_q.size() == 0) begin
                        errors++;
                        $display("FAIL tx_done_unexpected dut%0d: done at cycle %0d", k, cyc);
                    end else begin
                        d = done_q.pop_front();
                        if (d.id != k || d.cyc != cyc) begin
                            errors++;
                            $display("FAIL tx_done dut%0d: got cycle %0d, expected dut%0d cycle %0d", k, cyc, d.id, d.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int k, input logic [7:0] d, output int acc);
        bit ok;
        ok = 0;
        acc = 0;
        @(posedge clk); #1;
        tx_byte[k] = d;
        tx_dv[k] = 1'b1;
        for (int i = 0; i < 6000 && !ok; i++) begin
            @(negedge clk);
            if (tx_ready[k]) begin
                ok = 1;
                acc = cyc;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL tx_accept dut%0d: ready never seen, expected within 6000 cycles", k);
        end
        @(posedge clk); #1;
        tx_dv[k] = 1'b0;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drive_bit(input int k, input logic b);
        rx_in[k] = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic ext_frame(input int k, input logic [7:0] d, input bit use_par,
                             input logic pbit, input logic stopv);
        drive_bit(k, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(k, d[i]);
        if (use_par) drive_bit(k, pbit);
        drive_bit(k, stopv);
    endtask

    task automatic drain();
        for (int i = 0; i < 8000 && (rx_q.size() != 0 || done_q.size() != 0); i++)
            @(negedge clk);
        chk("drain_rx_queue", rx_q.size(), 0);
        chk("drain_done_queue", done_q.size(), 0);
    endtask

    initial begin
        int a, b;
        bit ok;
        for (int k = 0; k < 3; k++) tx_byte[k] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_tx_dut%0d", k), uart_tx[k], 1);
            chk($sformatf("reset_ready_dut%0d", k), tx_ready[k], 1);
            chk($sformatf("reset_done_dut%0d", k), tx_done[k], 0);
            chk($sformatf("reset_rxdv_dut%0d", k), rx_dv[k], 0);
            chk($sformatf("reset_rxbyte_dut%0d", k), rx_byte[k], 0);
            chk($sformatf("reset_errs_dut%0d", k), {perr[k], ferr[k]}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        lb = 3'b111;
        repeat (5) @(posedge clk);

        // 8N1 loopback 0x3F
        rx_q.push_back('{0, 8'h3F, 1'b0, 1'b0});
        send(0, 8'h3F, a);
        done_q.push_back('{0, a + frame_len(0)});
        drain();

        // 8E1 loopback 0xA5: line bits start=0, d0=1, parity=0
        rx_q.push_back('{1, 8'hA5, 1'b0, 1'b0});
        send(1, 8'hA5, a);
        done_q.push_back('{1, a + frame_len(1)});
        wait_to(a + 1 + CPB / 2);
        chk("p_line_start", uart_tx[1], 0);
        wait_to(a + 1 + CPB + CPB / 2);
        chk("p_line_d0", uart_tx[1], 1);
        wait_to(a + 1 + 9 * CPB + CPB / 2);
        chk("p_line_parity", uart_tx[1], 0);
        drain();

        // 8E1 external frames: flipped parity, then correct parity on 0x3C
        @(posedge clk); #1;
        lb[1] = 1'b0;
        rx_q.push_back('{1, 8'hA5, 1'b1, 1'b0});
        ext_frame(1, 8'hA5, 1, 1'b1, 1'b1);
        rx_q.push_back('{1, 8'h3C, 1'b0, 1'b0});
        ext_frame(1, 8'h3C, 1, 1'b0, 1'b1);
        drain();

        // 8N1 external frame with stop bit 0, line held low, then a good frame
        lb[0] = 1'b0;
        rx_q.push_back('{0, 8'h55, 1'b0, 1'b1});
        ext_frame(0, 8'h55, 0, 1'b0, 1'b0);
        repeat (2500) @(posedge clk);
        #1 rx_in[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rx_q.push_back('{0, 8'hC3, 1'b0, 1'b0});
        ext_frame(0, 8'hC3, 0, 1'b0, 1'b1);
        drain();

        // 50-cycle glitch, then a frame 110 cycles later
        @(posedge clk); #1;
        rx_in[0] = 1'b0;
        repeat (50) @(posedge clk);
        #1 rx_in[0] = 1'b1;
        repeat (110) @(posedge clk);
        #1;
        rx_q.push_back('{0, 8'h81, 1'b0, 1'b0});
        ext_frame(0, 8'h81, 0, 1'b0, 1'b1);
        drain();

        // 8N2 loopback, i_tx_dv held across 0x00 then 0xFF
        rx_q.push_back('{2, 8'h00, 1'b0, 1'b0});
        rx_q.push_back('{2, 8'hFF, 1'b0, 1'b0});
        @(posedge clk); #1;
        tx_byte[2] = 8'h00;
        tx_dv[2] = 1'b1;
        @(negedge clk);
        a = cyc;
        chk("b2b_first_ready", tx_ready[2], 1);
        done_q.push_back('{2, a + frame_len(2)});
        @(posedge clk); #1;
        tx_byte[2] = 8'hFF;
        ok = 0;
        b = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (tx_ready[2]) begin
                ok = 1;
                b = cyc;
            end
        end
        chk("b2b_second_accept_cycle", b, a + frame_len(2));
        chk("b2b_last_stop_line", uart_tx[2], 1);
        done_q.push_back('{2, b + frame_len(2)});
        @(posedge clk); #1;
        tx_dv[2] = 1'b0;
        @(negedge clk);
        chk("b2b_second_start_line", uart_tx[2], 0);
        drain();

        // Reset in the middle of data bit 3 of 0x96 (bit 3 = 0), then 0x5A
        send(0, 8'h96, a);
        lb[0] = 1'b1;
        wait_to(a + 1 + 4 * CPB + CPB / 2);
        chk("rst_line_bit3", uart_tx[0], 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_abort_line", uart_tx[0], 1);
        chk("rst_abort_ready", tx_ready[0], 1);
        repeat (2600) @(posedge clk);
        rx_q.push_back('{0, 8'h5A, 1'b0, 1'b0});
        send(0, 8'h5A, a);
        done_q.push_back('{0, a + frame_len(0)});
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
